coh_req_arb: RTL and testbench

COH_REQ_ARB -- requirements
Module: coh_req_arb

---
 rtl/coh_req_arb.sv | 181 ++++++++++++++++++
 tb/tb_coh_req_arb.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coh_req_arb.sv
// Coherence request arbiter: per-core request FIFOs merged round-robin onto one L2 request
// channel, with a single-entry response register fanned back out to the requesting core.
module coh_req_arb #(
  parameter int NCORES     = 4,
  parameter int LINE_BYTES = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCORES-1:0]         l1_req_valid,
  output logic [NCORES-1:0]         l1_req_ready,
  input  logic [NCORES*3-1:0]       l1_req_cmd,
  input  logic [NCORES*32-1:0]      l1_req_addr,
  output logic                      l2_req_valid,
  input  logic                      l2_req_ready,
  output logic [1:0]                l2_req_src,
  output logic [2:0]                l2_req_cmd,
  output logic [31:0]               l2_req_addr,
  input  logic                      l2_resp_valid,
  output logic                      l2_resp_ready,
  input  logic [1:0]                l2_resp_dst,
  input  logic [2:0]                l2_resp_cmd,
  input  logic [LINE_BYTES*8-1:0]   l2_resp_line,
  output logic [NCORES-1:0]         l1_resp_valid,
  input  logic [NCORES-1:0]         l1_resp_ready,
  output logic [2:0]                l1_resp_cmd,
  output logic [LINE_BYTES*8-1:0]   l1_resp_line,
  output logic                      protocol_err
);

  localparam int LW = LINE_BYTES * 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]    fifo_cmd  [NCORES][FIFO_DEPTH];
  logic [31:0]   fifo_addr [NCORES][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr    [NCORES];
  logic [PW-1:0] rd_ptr    [NCORES];
  logic [CW-1:0] count     [NCORES];

  logic [NCORES-1:0] out_q;
  logic [1:0]        last_grant;

  logic        req_valid_q;
  logic [1:0]  req_src_q;
  logic [2:0]  req_cmd_q;
  logic [31:0] req_addr_q;

  logic          resp_valid_q;
  logic [1:0]    resp_dst_q;
  logic [2:0]    resp_cmd_q;
  logic [LW-1:0] resp_line_q;

  logic err_q;

  logic [NCORES-1:0] fifo_full;
  logic [NCORES-1:0] push;
  logic [NCORES-1:0] pop;
  logic [NCORES-1:0] eligible;
  logic [NCORES-1:0] resp_sel;
  logic [NCORES-1:0] deliver;
  logic              win_any;
  logic [1:0]        win_idx;
  logic              load;
  logic              req_take;
  logic              resp_drain;
  logic              resp_ready_int;
  logic              resp_take;

  always_comb begin : fifo_status
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    fifo_full = '0;
    push      = '0;
    eligible  = '0;
    for (int i = 0; i < NCORES; i++) begin
      fifo_full[i] = (count[i] == CW'(FIFO_DEPTH));
      push[i]      = l1_req_valid[i] && !fifo_full[i] && !rst;
      eligible[i]  = (count[i] != '0) && !out_q[i];
    end
  end

  // Search starts one past the previous winner and wraps, so the previous winner is tried last.
  always_comb begin : rr_pick
    logic [1:0] cand;
    cand    = '0;
    win_any = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NCORES; k++) begin
      cand = last_grant + 2'(k);
      if (!win_any && eligible[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign load           = win_any && (!req_valid_q || l2_req_ready);
  assign pop            = load ? (NCORES'(1) << win_idx) : '0;
  assign req_take       = req_valid_q && l2_req_ready;
  assign resp_sel       = resp_valid_q ? (NCORES'(1) << resp_dst_q) : '0;
  assign deliver        = resp_sel & l1_resp_ready;
  assign resp_drain     = |deliver;
  assign resp_ready_int = !resp_valid_q || resp_drain;
  assign resp_take      = l2_resp_valid && resp_ready_int && !rst;

  always_ff @(posedge clk) begin : fifo_mem
    // NOTE: FIFO storage has no reset; entries are only read behind count, so stale data is never seen.
    for (int i = 0; i < NCORES; i++) begin
      if (push[i]) begin
        fifo_cmd[i][wr_ptr[i]]  <= l1_req_cmd[i*3 +: 3];
        fifo_addr[i][wr_ptr[i]] <= l1_req_addr[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin : ctrl_regs
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      for (int i = 0; i < NCORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      out_q        <= '0;
      last_grant   <= 2'd3;
      req_valid_q  <= 1'b0;
      req_src_q    <= '0;
      req_cmd_q    <= '0;
      req_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_dst_q   <= '0;
      resp_cmd_q   <= '0;
      resp_line_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end

      // Set is OR-ed in after the clear, so a same-cycle set wins.
      out_q <= (out_q & ~deliver) | pop;

      if (load) begin
        req_valid_q <= 1'b1;
        req_src_q   <= win_idx;
        req_cmd_q   <= fifo_cmd[win_idx][rd_ptr[win_idx]];
        req_addr_q  <= fifo_addr[win_idx][rd_ptr[win_idx]];
        last_grant  <= win_idx;
      end else if (req_take) begin
        req_valid_q <= 1'b0;
      end

      if (resp_take) begin
        resp_valid_q <= 1'b1;
        resp_dst_q   <= l2_resp_dst;
        resp_cmd_q   <= l2_resp_cmd;
        resp_line_q  <= l2_resp_line;
        if (!out_q[l2_resp_dst]) err_q <= 1'b1;
      end else if (resp_drain) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  // Handshake readies and payloads are forced low while reset is held.
  always_comb begin : out_drive
    l1_req_ready  = rst ? '0 : ~fifo_full;
    l2_req_valid  = req_valid_q;
    l2_req_src    = rst ? '0 : req_src_q;
    l2_req_cmd    = rst ? '0 : req_cmd_q;
    l2_req_addr   = rst ? '0 : req_addr_q;
    l2_resp_ready = !rst && resp_ready_int;
    l1_resp_valid = resp_sel;
    l1_resp_cmd   = rst ? '0 : resp_cmd_q;
    l1_resp_line  = rst ? '0 : resp_line_q;
    protocol_err  = err_q;
  end

endmodule

// File: tb/tb_coh_req_arb.sv
// Self-checking bench for coh_req_arb: directed scenarios plus a randomized run, all cycles
// compared against a queue-based reference model of the arbiter's rules.
module tb_coh_req_arb;

  localparam int NCORES     = 4;
  localparam int LINE_BYTES = 32;
  localparam int LW         = LINE_BYTES * 8;
  localparam int FIFO_DEPTH = 2;

  localparam logic [2:0] GETS      = 3'd0;
  localparam logic [2:0] GETM      = 3'd1;
  localparam logic [2:0] DATA      = 3'd4;
  localparam logic [2:0] DATA_EXCL = 3'd5;

  logic                 clk;
  logic                 rst;
  logic [NCORES-1:0]    l1_req_valid;
  logic [NCORES-1:0]    l1_req_ready;
  logic [NCORES*3-1:0]  l1_req_cmd;
  logic [NCORES*32-1:0] l1_req_addr;
  logic                 l2_req_valid;
  logic                 l2_req_ready;
  logic [1:0]           l2_req_src;
  logic [2:0]           l2_req_cmd;
  logic [31:0]          l2_req_addr;
  logic                 l2_resp_valid;
  logic                 l2_resp_ready;
  logic [1:0]           l2_resp_dst;
  logic [2:0]           l2_resp_cmd;
  logic [LW-1:0]        l2_resp_line;
  logic [NCORES-1:0]    l1_resp_valid;
  logic [NCORES-1:0]    l1_resp_ready;
  logic [2:0]           l1_resp_cmd;
  logic [LW-1:0]        l1_resp_line;
  logic                 protocol_err;

  coh_req_arb #(.NCORES(NCORES), .LINE_BYTES(LINE_BYTES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .l1_req_valid(l1_req_valid), .l1_req_ready(l1_req_ready),
    .l1_req_cmd(l1_req_cmd), .l1_req_addr(l1_req_addr),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
    .l2_req_src(l2_req_src), .l2_req_cmd(l2_req_cmd), .l2_req_addr(l2_req_addr),
    .l2_resp_valid(l2_resp_valid), .l2_resp_ready(l2_resp_ready),
    .l2_resp_dst(l2_resp_dst), .l2_resp_cmd(l2_resp_cmd), .l2_resp_line(l2_resp_line),
    .l1_resp_valid(l1_resp_valid), .l1_resp_ready(l1_resp_ready),
    .l1_resp_cmd(l1_resp_cmd), .l1_resp_line(l1_resp_line),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
  } req_t;

  // Reference model state
  req_t          mq [NCORES][$];
  logic [3:0]    m_out;
  int            m_lg;
  bit            m_oval;
  int            m_osrc;
  logic [2:0]    m_ocmd;
  logic [31:0]   m_oaddr;
  bit            m_rval;
  int            m_rdst;
  logic [2:0]    m_rcmd;
  logic [LW-1:0] m_rline;
  bit            m_err;

  int pend[$];
  int obs_log[$];
  bit req_hs, resp_hs;
  bit auto_l2;
  int rdelay, rdelay_max;
  int checks, errors;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int j = 0; j < LW / 32; j++) r[j*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCORES; i++) mq[i].delete();
    m_out = '0; m_lg = 3;
    m_oval = 0; m_osrc = 0; m_ocmd = '0; m_oaddr = '0;
    m_rval = 0; m_rdst = 0; m_rcmd = '0; m_rline = '0;
    m_err = 0;
    pend.delete();
  endtask

  // Compares this cycle's outputs, then advances the model by the rules of one clock edge.
  task automatic model_step();
    logic [3:0] exp_ready, exp_rv;
    logic       exp_l2rr, dlv, rtake, qtake;
    int         win, c;
    req_t       r;
    req_hs = 0;
    resp_hs = 0;
    exp_rv = m_rval ? (4'b0001 << m_rdst) : 4'b0000;
    check("l2_req_valid", l2_req_valid, m_oval);
    check("l1_resp_valid", l1_resp_valid, exp_rv);
    check("protocol_err", protocol_err, m_err);
    if (rst) begin
      check("rst_l1_req_ready", l1_req_ready, 0);
      check("rst_l2_resp_ready", l2_resp_ready, 0);
      check("rst_l2_req_src", l2_req_src, 0);
      check("rst_l2_req_addr", l2_req_addr, 0);
      check("rst_l1_resp_line", l1_resp_line, 0);
      model_reset();
      return;
    end
    if (l2_req_valid && l2_req_ready) obs_log.push_back(int'(l2_req_src));
    for (int i = 0; i < NCORES; i++) exp_ready[i] = (mq[i].size() < FIFO_DEPTH);
    check("l1_req_ready", l1_req_ready, exp_ready);
    if (m_oval) begin
      check("l2_req_src", l2_req_src, m_osrc[1:0]);
      check("l2_req_cmd", l2_req_cmd, m_ocmd);
      check("l2_req_addr", l2_req_addr, m_oaddr);
    end
    if (m_rval) begin
      check("l1_resp_cmd", l1_resp_cmd, m_rcmd);
      check("l1_resp_line", l1_resp_line, m_rline);
    end
    exp_l2rr = !m_rval || l1_resp_ready[m_rdst];
    check("l2_resp_ready", l2_resp_ready, exp_l2rr);

    dlv   = m_rval && l1_resp_ready[m_rdst];
    rtake = l2_resp_valid && exp_l2rr;
    qtake = m_oval && l2_req_ready;
    if (rtake && !m_out[l2_resp_dst]) m_err = 1;
    win = -1;
    for (int k = 1; k <= NCORES; k++) begin
      c = (m_lg + k) % NCORES;
      if (win < 0 && mq[c].size() != 0 && !m_out[c]) win = c;
    end
    if (dlv) m_out[m_rdst] = 1'b0;
    if (qtake) begin
      req_hs = 1;
      pend.push_back(m_osrc);
    end
    if (win >= 0 && (!m_oval || l2_req_ready)) begin
      r = mq[win].pop_front();
      m_out[win] = 1'b1;
      m_oval = 1; m_osrc = win; m_ocmd = r.cmd; m_oaddr = r.addr;
      m_lg = win;
    end else if (qtake) begin
      m_oval = 0;
    end
    if (rtake) begin
      resp_hs = 1;
      m_rval = 1; m_rdst = int'(l2_resp_dst); m_rcmd = l2_resp_cmd; m_rline = l2_resp_line;
    end else if (dlv) begin
      m_rval = 0;
    end
    for (int i = 0; i < NCORES; i++) begin
      if (l1_req_valid[i] && exp_ready[i]) begin
        r.cmd  = l1_req_cmd[i*3 +: 3];
        r.addr = l1_req_addr[i*32 +: 32];
        mq[i].push_back(r);
      end
    end
  endtask

  // Behavioural L2: answers accepted requests in order after a random delay.
  task automatic l2_responder();
    if (resp_hs) l2_resp_valid = 1'b0;
    if (!l2_resp_valid && pend.size() > 0) begin
      if (rdelay == 0) begin
        l2_resp_valid = 1'b1;
        l2_resp_dst   = 2'(pend.pop_front());
        l2_resp_cmd   = ($urandom_range(0, 1) == 0) ? DATA : DATA_EXCL;
        l2_resp_line  = rand_line();
        rdelay        = $urandom_range(0, rdelay_max);
      end else begin
        rdelay--;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (auto_l2) l2_responder();
  endtask

  task automatic set_req(input int i, input logic [2:0] cmd, input logic [31:0] addr);
    l1_req_cmd[i*3 +: 3]   = cmd;
    l1_req_addr[i*32 +: 32] = addr;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    auto_l2 = 0;
    l1_req_valid = '0; l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l1_resp_ready = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic send_resp(input logic [1:0] dst, input logic [2:0] cmd, input logic [LW-1:0] line);
    l2_resp_valid = 1'b1; l2_resp_dst = dst; l2_resp_cmd = cmd; l2_resp_line = line;
    for (int n = 0; n < 20; n++) begin
      step();
      if (resp_hs) break;
    end
    check("resp_handshake", resp_hs, 1);
    l2_resp_valid = 1'b0;
  endtask

  task automatic drive_random();
    logic [31:0] a;
    for (int i = 0; i < NCORES; i++) begin
      a = $urandom();
      a[4:0] = '0;
      l1_req_valid[i] = ($urandom_range(0, 1) == 1);
      set_req(i, 3'($urandom_range(0, 3)), a);
    end
    l2_req_ready  = ($urandom_range(0, 9) < 7);
    l1_resp_ready = 4'($urandom_range(0, 15));
  endtask

  initial begin
    logic [LW-1:0] line_a, line_b;
    clk = 0; rst = 1;
    l1_req_valid = '0; l1_req_cmd = '0; l1_req_addr = '0;
    l2_req_ready = 0; l2_resp_valid = 0; l2_resp_dst = '0; l2_resp_cmd = '0; l2_resp_line = '0;
    l1_resp_ready = '0;
    auto_l2 = 0; rdelay = 0; rdelay_max = 0; checks = 0; errors = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Single request, core blocked until its response is accepted
    apply_reset();
    check("ready_after_rst", l1_req_ready, 4'hf);
    l2_req_ready = 1'b1;
    set_req(2, GETS, 32'h0000_1000);
    l1_req_valid = 4'b0100;
    step();
    l1_req_valid = '0;
    step();
    check("t1_l2_valid", l2_req_valid, 1);
    check("t1_src", l2_req_src, 2'd2);
    check("t1_addr", l2_req_addr, 32'h0000_1000);
    set_req(2, GETM, 32'h0000_2000);
    l1_req_valid = 4'b0100;
    step();
    l1_req_valid = '0;
    repeat (4) step();
    check("t1_blocked", l2_req_valid, 0);
    l1_resp_ready = 4'b0100;
    line_a = rand_line();
    send_resp(2'd2, DATA, line_a);
    check("t1_resp_valid", l1_resp_valid, 4'b0100);
    check("t1_resp_line", l1_resp_line, line_a);
    step();
    step();
    check("t1_second_src", l2_req_src, 2'd2);
    check("t1_second_addr", l2_req_addr, 32'h0000_2000);

    // Fairness with continuous requests and immediate responses
    apply_reset();
    for (int i = 0; i < NCORES; i++) set_req(i, GETM, 32'h0001_0000 * (i + 1));
    l1_req_valid = 4'hf; l2_req_ready = 1'b1; l1_resp_ready = 4'hf;
    auto_l2 = 1; rdelay_max = 0; rdelay = 0;
    obs_log.delete();
    repeat (40) step();
    for (int k = 0; k < 8; k++)
      check("fair_order", (k < obs_log.size()) ? obs_log[k] : -1, k % NCORES);
    auto_l2 = 0;

    // Backpressure: held request stays stable, FIFOs fill then deassert ready
    apply_reset();
    for (int i = 0; i < NCORES; i++) set_req(i, 3'(i + 1), 32'h100 * (i + 1));
    l1_req_valid = 4'hf; l2_req_ready = 1'b0;
    step();
    step();
    for (int n = 0; n < 10; n++) begin
      step();
      check("bp_valid", l2_req_valid, 1);
      check("bp_src", l2_req_src, 2'd0);
      check("bp_cmd", l2_req_cmd, 3'd1);
      check("bp_addr", l2_req_addr, 32'h100);
    end
    check("bp_ready_low", l1_req_ready, 4'b0000);

    // Response stall on core 1 holds off a second response
    apply_reset();
    set_req(1, GETM, 32'h0000_4000);
    l1_req_valid = 4'b0010; l2_req_ready = 1'b1;
    step();
    l1_req_valid = '0;
    step();
    step();
    l1_resp_ready = '0;
    line_a = rand_line();
    send_resp(2'd1, DATA_EXCL, line_a);
    check("t4_resp_valid", l1_resp_valid, 4'b0010);
    line_b = rand_line();
    l2_resp_valid = 1'b1; l2_resp_dst = 2'd1; l2_resp_cmd = DATA; l2_resp_line = line_b;
    for (int n = 0; n < 3; n++) begin
      step();
      check("t4_stall_ready", l2_resp_ready, 0);
      check("t4_stall_cmd", l1_resp_cmd, DATA_EXCL);
    end
    l1_resp_ready = 4'b0010;
    #1;
    check("t4_drain_ready", l2_resp_ready, 1);
    step();
    l2_resp_valid = 1'b0;
    check("t4_second_cmd", l1_resp_cmd, DATA);
    check("t4_second_line", l1_resp_line, line_b);
    step();
    check("t4_empty", l1_resp_valid, 4'b0000);
    check("t4_no_err", protocol_err, 0);

    // Spurious response is delivered and flags a sticky error
    apply_reset();
    l1_resp_ready = 4'b1000;
    send_resp(2'd3, DATA, rand_line());
    check("t5_resp_valid", l1_resp_valid, 4'b1000);
    check("t5_err_set", protocol_err, 1);
    repeat (3) step();
    check("t5_err_sticky", protocol_err, 1);
    apply_reset();
    check("t5_err_cleared", protocol_err, 0);

    // Reset in the middle of traffic
    apply_reset();
    set_req(1, GETS, 32'h0000_8000);
    l1_req_valid = 4'b0010; l2_req_ready = 1'b0;
    step();
    l1_req_valid = '0;
    step();
    l1_resp_ready = '0;
    send_resp(2'd1, DATA, rand_line());
    check("t6_req_held", l2_req_valid, 1);
    check("t6_resp_full", l1_resp_valid, 4'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_req_cleared", l2_req_valid, 0);
    check("t6_resp_cleared", l1_resp_valid, 4'b0000);
    check("t6_resp_ready", l2_resp_ready, 1);
    for (int i = 0; i < NCORES; i++) set_req(i, GETS, 32'h20 * (i + 1));
    l1_req_valid = 4'hf; l2_req_ready = 1'b1;
    step();
    step();
    check("t6_first_winner", l2_req_src, 2'd0);

    // Randomized traffic against the model
    apply_reset();
    auto_l2 = 1; rdelay_max = 4; rdelay = 0;
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      step();
    end
    l1_req_valid = '0; l1_resp_ready = 4'hf; l2_req_ready = 1'b1;
    repeat (50) step();
    check("drain_idle", l2_req_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
